// File: rtl/i2c_rx_fifo.sv
// rtl/i2c_rx_fifo.sv - I2C receive byte FIFO with registered APB read data and sticky status flags
module i2c_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       pclk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       wr_en,
    input  logic [1:0]                 rx_r_ena,
    input  logic                       flush,
    input  logic                       status_clear,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             pop_req;
    logic             pop_ok;
    logic             push_ok;
    logic             ovf_set;
    logic             udf_set;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_req = (rx_r_ena == 2'b11);

    // A pop frees a slot in the same edge, so a full FIFO still accepts a concurrent push.
    assign pop_ok  = !flush && pop_req && !empty;
    assign push_ok = !flush && wr_en && (!full || pop_ok);
    assign ovf_set = !flush && wr_en && full && !pop_ok;
    assign udf_set = !flush && pop_req && empty;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_next;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop_ok) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + PW'(1);
                end
            end
            // A new event in the same cycle as a clear keeps the flag set.
            overflow  <= (overflow  && !status_clear) || ovf_set;
            underflow <= (underflow && !status_clear) || udf_set;
        end
    end
endmodule

// File: tb/tb_i2c_rx_fifo.sv
// tb/tb_i2c_rx_fifo.sv - scoreboard bench for i2c_rx_fifo against a queue-based reference model
module tb_i2c_rx_fifo;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             pclk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] wr_data = '0;
    logic             wr_en = 1'b0;
    logic [1:0]       rx_r_ena = 2'b00;
    logic             flush = 1'b0;
    logic             status_clear = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ov, m_un, pop_fired;
    logic [WIDTH-1:0] last_rd;

    i2c_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .pclk(pclk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
        .rx_r_ena(rx_r_ena), .flush(flush), .status_clear(status_clear),
        .rd_data(rd_data), .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue; a pop is served before the push of the same edge.
    always @(posedge pclk or posedge rst) begin
        if (rst) begin
            mq.delete();
            exp_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            pop_fired = 1'b0;
            last_rd = '0;
        end else begin
            logic ov_new, un_new;
            ov_new = 1'b0;
            un_new = 1'b0;
            pop_fired = 1'b0;
            if (flush) begin
                mq.delete();
            end else begin
                if (rx_r_ena == 2'b11) begin
                    if (mq.size() > 0) begin
                        exp_q.push_back(mq.pop_front());
                        pop_fired = 1'b1;
                    end else begin
                        un_new = 1'b1;
                    end
                end
                if (wr_en) begin
                    if (mq.size() < DEPTH) mq.push_back(wr_data);
                    else ov_new = 1'b1;
                end
            end
            m_ov = (m_ov && !status_clear) || ov_new;
            m_un = (m_un && !status_clear) || un_new;
        end
    end

    // Monitor: compares every settled cycle; read data after a pop, otherwise the held value.
    always @(negedge pclk) begin
        if (!rst) begin
            check("count", 32'(count), 32'(mq.size()));
            check("full", 32'(full), 32'(mq.size() == DEPTH));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("overflow", 32'(overflow), 32'(m_ov));
            check("underflow", 32'(underflow), 32'(m_un));
            if (pop_fired) begin
                last_rd = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(last_rd));
            end else begin
                check("rd_hold", 32'(rd_data), 32'(last_rd));
            end
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic [1:0] e,
                       input logic f, input logic s);
        @(negedge pclk);
        wr_en = w; wr_data = d; rx_r_ena = e; flush = f; status_clear = s;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_count"}, 32'(count), 32'h0);
        check({tag, "_empty"}, 32'(empty), 32'h1);
        check({tag, "_full"}, 32'(full), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_underflow"}, 32'(underflow), 32'h0);
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        @(negedge pclk);
        rst = 1'b0;

        push(8'hA1); push(8'hB2); push(8'hC3);
        pop();
        repeat (3) cyc(1'b0, 8'h00, 2'b10, 1'b0, 1'b0);
        pop(); pop();
        idle();

        for (int i = 0; i < 8; i++) push(8'(i));
        push(8'hFF);
        for (int i = 0; i < 8; i++) pop();
        idle();

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) push(8'(16 * r + i + 8'h40));
            for (int i = 0; i < 5; i++) pop();
        end
        idle();

        pop();
        cyc(1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 2'b11, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 2'b01, 1'b0, 1'b1);
        idle();

        for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
        cyc(1'b1, 8'h64, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
        cyc(1'b1, 8'h7A, 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pop();
        cyc(1'b1, 8'h99, 2'b11, 1'b0, 1'b0);
        pop();
        idle();

        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
        cyc(1'b1, 8'hEE, 2'b11, 1'b1, 1'b0);
        idle();

        push(8'h11); push(8'h22); pop();
        cyc(1'b1, 8'h33, 2'b10, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge pclk);
        wr_en = 1'b0; rx_r_ena = 2'b00; flush = 1'b0; status_clear = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1) == 1, 8'($urandom), 2'($urandom_range(0, 3)),
                $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0);
        end
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2c_rx_fifo.md
Name: i2c_rx_fifo

Overview:
- Receive-data buffer between the I2C byte engine (write side) and the APB register decode stage (read side).
- Buffers received bytes and presents the head byte on a registered read-data output.
- Pops on the one-cycle RX read strobe from the address decoder and holds read data stable for the remainder of the APB transfer.
- Reports full/empty, fill level and sticky overflow/underflow to the status register.

Parameters:
DEPTH, 8, number of byte entries; power of 2, minimum 2.
WIDTH, 8, data width in bits.

Ports:
pclk  input  1  APB clock; the only clock.
rst  input  1  asynchronous, active-high reset.
wr_data  input  WIDTH  received byte from the I2C byte engine.
wr_en  input  1  push strobe, one cycle per byte.
rx_r_ena  input  2  from decoder: 2'b11 = pop/load cycle; 2'b10 = hold cycle; 2'b00 = idle.
flush  input  1  synchronous clear from control register write.
status_clear  input  1  from decoder: clears sticky flags.
rd_data  output  WIDTH  registered head byte returned to APB prdata mux.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  $clog2(DEPTH)+1  current fill level.
overflow  output  1  sticky; push attempted while full.
underflow  output  1  sticky; pop attempted while empty.

Behaviour:
- Reset (async, rst=1): pointers=0; count=0; rd_data=0; overflow=0; underflow=0; empty=1; full=0.
- Storage: DEPTH x WIDTH array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping naturally at DEPTH-1 -> 0.
  - count is held separately; full and empty are derived combinationally from count.
- Push: wr_en=1 and not full -> mem[wr_ptr] <= wr_data, wr_ptr+1, count+1.
  - wr_en=1 while full -> data dropped, no pointer change, overflow <= 1.
- Pop: only on a cycle where rx_r_ena==2'b11.
  - Not empty -> rd_data <= mem[rd_ptr], rd_ptr+1, count-1.
  - Empty -> rd_data unchanged, underflow <= 1.
- Read latency: rd_data is valid on the edge after the 2'b11 cycle. It is then held unchanged through all 2'b10 and 2'b00 cycles until the next pop.
- rx_r_ena==2'b01 is illegal. It is treated as 2'b00, with no pop.
- Simultaneous push and pop, count not 0 and not DEPTH:
  - both pointers advance; count unchanged.
- Simultaneous push and pop with count==0:
  - the push is performed; the pop is an underflow and rd_data is unchanged (no fall-through).
  - Result: count=1, underflow=1.
- Simultaneous push and pop with count==DEPTH:
  - the pop is performed and the push is accepted in the same edge (the slot is freed by the read).
  - count stays DEPTH; no overflow.
- flush=1: pointers <= 0, count <= 0. rd_data and the sticky flags are unaffected.
  - flush has priority over push and pop in the same cycle; both are ignored and neither sets a flag.
- status_clear=1: overflow <= 0, underflow <= 0.
  - If a new overflow or underflow event occurs in the same cycle, the set wins and the flag stays 1.
- Reset mid-operation: all state returns to reset values immediately, regardless of the current rx_r_ena or wr_en.
- No combinational path from any input to any output except full, empty and count from internal state.

Test Plan:
- Reset with DEPTH=8: push 0xA1, 0xB2, 0xC3 -> count=3, empty=0. Drive rx_r_ena 11 then 10 x3 -> rd_data=0xA1 one cycle after the 11 cycle and held while 10; count=2.
- Push 8 bytes 0x00..0x07 -> full=1, count=8. Push 0xFF -> overflow=1, count=8. Pop 8 times -> rd_data sequence 0x00..0x07 (0xFF never appears), empty=1.
- Wrap-around: repeat 3 rounds of push 5 / pop 5 -> data order preserved across the pointer wrap, count=0 at the end.
- Pop when empty -> underflow=1, rd_data keeps its last value. status_clear -> underflow=0. status_clear coincident with a new underflow -> underflow=1.
- Simultaneous wr_en and rx_r_ena=11:
  - at count=4 -> count=4.
  - at count=8 -> count=8, overflow=0.
  - at count=0 -> count=1, underflow=1.
- flush with count=5 coincident with wr_en -> count=0, empty=1, overflow unchanged. Assert rst mid-transfer -> all outputs at reset values immediately.
